// File: rtl/sequence_player_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sequence_player_if: request/replay bundle between a controller and
// sequence_player. Rev 1.0
// ---------------------------------------------------------------------------
interface sequence_player_if;
  logic       start;
  logic       abort;
  logic       send_enter;
  logic [3:0] len;
  logic [6:0] col1;
  logic [6:0] col2;
  logic [6:0] col3;
  logic [6:0] col4;
  logic       btn1;
  logic       btn2;
  logic       btn3;
  logic       btn4;
  logic       enter;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] pos;

  modport master (
    output start, abort, send_enter, len, col1, col2, col3, col4,
    input  btn1, btn2, btn3, btn4, enter, busy, done, err, pos
  );

  modport slave (
    input  start, abort, send_enter, len, col1, col2, col3, col4,
    output btn1, btn2, btn3, btn4, enter, busy, done, err, pos
  );
endinterface
`default_nettype wire

// File: rtl/sequence_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sequence_player: replays a latched one-hot secret sequence as timed button
// pulses, optionally followed by an enter pulse. Rev 1.0
// ---------------------------------------------------------------------------
module sequence_player #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 4,
  parameter int MIN_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  sequence_player_if.slave bus
);

  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       MIN_LEN_C    = 4'(MIN_LEN);
  localparam logic [3:0]       MAX_LEN_C    = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_ENTER = 3'd4,
    S_EGAP  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          pos_q, pos_d;
  logic [3:0]          len_q, len_d;
  logic [3:0][6:0]     col_q, col_d;
  logic                send_enter_q, send_enter_d;
  logic [3:0]          btn_q, btn_d;
  logic                enter_q, enter_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                seq_valid;
  logic                last_slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pos_q        <= '0;
      len_q        <= '0;
      col_q        <= '0;
      send_enter_q <= 1'b0;
      btn_q        <= '0;
      enter_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      len_q        <= len_d;
      col_q        <= col_d;
      send_enter_q <= send_enter_d;
      btn_q        <= btn_d;
      enter_q      <= enter_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Slots at or beyond len are don't-care; each used slot needs exactly one column.
  always_comb begin
    seq_valid = (len_q >= MIN_LEN_C) && (len_q <= MAX_LEN_C);
    for (int i = 0; i < 7; i++) begin
      if (4'(i) < len_q) begin
        if ($countones({col_q[3][i], col_q[2][i], col_q[1][i], col_q[0][i]}) != 1) begin
          seq_valid = 1'b0;
        end
      end
    end
  end

  assign last_slot = ({1'b0, pos_q} == (len_q - 4'd1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    len_d        = len_q;
    col_d        = col_q;
    send_enter_d = send_enter_q;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        pos_d = '0;
        if (bus.start && !bus.abort) begin
          len_d        = bus.len;
          col_d        = {bus.col4, bus.col3, bus.col2, bus.col1};
          send_enter_d = bus.send_enter;
          cnt_d        = '0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        pos_d = '0;
        if (seq_valid) begin
          cnt_d   = PULSE_RELOAD;
          state_d = S_PULSE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_RELOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (!last_slot) begin
            pos_d   = pos_q + 3'd1;
            cnt_d   = PULSE_RELOAD;
            state_d = S_PULSE;
          end else if (send_enter_q) begin
            cnt_d   = PULSE_RELOAD;
            state_d = S_ENTER;
          end else begin
            cnt_d   = '0;
            state_d = S_FIN;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ENTER: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_RELOAD;
          state_d = S_EGAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_EGAP: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIN: begin
        pos_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        pos_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pos_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so every output is a flop aligned with state_q.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    enter_d = (state_d == S_ENTER);
    btn_d   = '0;
    for (int k = 0; k < 4; k++) begin
      btn_d[k] = (state_d == S_PULSE) && col_q[k][pos_d];
    end
  end

  assign bus.btn1  = btn_q[0];
  assign bus.btn2  = btn_q[1];
  assign bus.btn3  = btn_q[2];
  assign bus.btn4  = btn_q[3];
  assign bus.enter = enter_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.pos   = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sequence_player: table-driven cycle-by-cycle bench for sequence_player,
// default timing (4/4) and 1/1 timing instances. Rev 1.0
// ---------------------------------------------------------------------------
module tb_sequence_player;

  logic clk;
  logic reset;

  sequence_player_if a_if ();
  sequence_player_if b_if ();

  sequence_player dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  sequence_player #(
    .PULSE_W (1),
    .GAP_W   (1),
    .MIN_LEN (4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;       // 0: 4/4 timing, 1: 1/1 timing
    logic [3:0]  len;
    logic [6:0]  c1;
    logic [6:0]  c2;
    logic [6:0]  c3;
    logic [6:0]  c4;
    logic        se;
    logic [31:0] seq;       // button per slot, one nibble each, first slot in top nibble
    int          exp_busy;
    logic        exp_err;
    logic        restart;
  } vec_t;

  vec_t vecs[10];
  int   errors;
  int   checks;

  // word layout: busy, done, err, btn4, btn3, btn2, btn1, enter, pos[2:0]
  function automatic logic [10:0] sample(input int d);
    if (d == 0)
      return {a_if.busy, a_if.done, a_if.err, a_if.btn4, a_if.btn3, a_if.btn2,
              a_if.btn1, a_if.enter, a_if.pos};
    else
      return {b_if.busy, b_if.done, b_if.err, b_if.btn4, b_if.btn3, b_if.btn2,
              b_if.btn1, b_if.enter, b_if.pos};
  endfunction

  function automatic logic [10:0] expect_word(input vec_t v, input int n);
    logic [10:0] w;
    int p;
    int per;
    int t;
    int slot;
    int ph;
    int sym;
    w   = '0;
    p   = (v.dut == 0) ? 4 : 1;
    per = 2 * p;
    if (n <= v.exp_busy) begin
      w[10] = 1'b1;
      if (!v.exp_err && n == v.exp_busy) begin
        w[9]   = 1'b1;
        w[2:0] = 3'(v.len - 4'd1);
      end else if (!v.exp_err && n >= 2) begin
        t    = n - 2;
        slot = t / per;
        ph   = t % per;
        if (slot < int'(v.len)) begin
          w[2:0] = 3'(slot);
          sym    = int'((v.seq >> (28 - 4 * slot)) & 32'hF);
          if (ph < p) w[3 + sym] = 1'b1;
        end else begin
          w[2:0] = 3'(v.len - 4'd1);
          if (ph < p) w[3] = 1'b1;
        end
      end
    end else if (v.exp_err && n == v.exp_busy + 1) begin
      w[8] = 1'b1;
    end
    return w;
  endfunction

  task automatic check(input string name, input int tag, input logic [10:0] got,
                       input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %b expected %b (busy,done,err,btn4..1,enter,pos)",
               name, tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic ab, input logic se,
                       input logic [3:0] ln, input logic [6:0] c1, input logic [6:0] c2,
                       input logic [6:0] c3, input logic [6:0] c4);
    if (d == 0) begin
      a_if.start = st; a_if.abort = ab; a_if.send_enter = se; a_if.len = ln;
      a_if.col1 = c1; a_if.col2 = c2; a_if.col3 = c3; a_if.col4 = c4;
    end else begin
      b_if.start = st; b_if.abort = ab; b_if.send_enter = se; b_if.len = ln;
      b_if.col1 = c1; b_if.col2 = c2; b_if.col3 = c3; b_if.col4 = c4;
    end
  endtask

  task automatic set_ctl(input int d, input logic st, input logic ab);
    if (d == 0) begin
      a_if.start = st; a_if.abort = ab;
    end else begin
      b_if.start = st; b_if.abort = ab;
    end
  endtask

  // Starts vector idx and compares every cycle; abort_at > 0 aborts after that cycle.
  task automatic run_vec(input int idx, input int abort_at);
    vec_t v;
    int w_len;
    logic [10:0] exp;
    v     = vecs[idx];
    w_len = (abort_at > 0) ? abort_at + 4 : v.exp_busy + 3;
    @(negedge clk);
    drive(v.dut, 1'b1, 1'b0, v.se, v.len, v.c1, v.c2, v.c3, v.c4);
    @(negedge clk);
    set_ctl(v.dut, 1'b0, 1'b0);
    for (int n = 1; n <= w_len; n++) begin
      if (n > 1) @(negedge clk);
      exp = (abort_at > 0 && n > abort_at) ? 11'b0 : expect_word(v, n);
      check($sformatf("vec%0d", idx), n, sample(v.dut), exp);
      set_ctl(v.dut, v.restart && (n == 10 || n == 25), (abort_at > 0 && n == abort_at));
    end
    set_ctl(v.dut, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // dut, len, col1, col2, col3, col4, send_enter, seq, busy, err, restart
    vecs[0] = '{0, 4'd4, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 1'b1, 32'h1234_0000, 42, 1'b0, 1'b0};
    vecs[1] = '{0, 4'd7, 7'b1010101, 7'b0000000, 7'b0101010, 7'b0000000, 1'b0, 32'h1313_1310, 58, 1'b0, 1'b0};
    vecs[2] = '{0, 4'd3, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0000000, 1'b1, 32'h0, 1, 1'b1, 1'b0};
    vecs[3] = '{0, 4'd4, 7'b0000011, 7'b0000010, 7'b0000100, 7'b0001000, 1'b1, 32'h0, 1, 1'b1, 1'b0};
    vecs[4] = '{0, 4'd4, 7'b0000001, 7'b0000010, 7'b0000000, 7'b0001000, 1'b0, 32'h0, 1, 1'b1, 1'b0};
    vecs[5] = '{0, 4'd4, 7'b0100010, 7'b0100100, 7'b0001000, 7'b0000001, 1'b0, 32'h4123_0000, 34, 1'b0, 1'b0};
    vecs[6] = '{0, 4'd8, 7'b1111111, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 32'h0, 1, 1'b1, 1'b0};
    vecs[7] = '{0, 4'd5, 7'b0000000, 7'b0011111, 7'b0000000, 7'b0000000, 1'b1, 32'h2222_2000, 50, 1'b0, 1'b1};
    vecs[8] = '{1, 4'd4, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000, 1'b1, 32'h1234_0000, 12, 1'b0, 1'b0};
    vecs[9] = '{1, 4'd7, 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111, 1'b0, 32'h4444_4440, 16, 1'b0, 1'b0};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    check("reset_a", 0, sample(0), 11'b0);
    check("reset_b", 0, sample(1), 11'b0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(i, 0);
    end

    // Abort in the second cycle of the third button pulse, then a clean replay.
    run_vec(0, 19);
    run_vec(0, 0);

    // start together with abort in IDLE must not launch a replay.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 4'd4, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      if (n > 1) @(negedge clk);
      check("start_abort_idle", n, sample(0), 11'b0);
    end

    // Asynchronous reset in the middle of the first gap.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1, 4'd4, 7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("pre_reset_gap", 7, sample(0), expect_word(vecs[0], 7));
    #1 reset = 1'b1;
    #1 check("async_reset", 7, sample(0), 11'b0);
    @(negedge clk);
    check("held_reset", 8, sample(0), 11'b0);
    reset = 1'b0;
    run_vec(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
